// File: rtl/yutorina_instruction_decode_pkg.sv
// Shared ISA definitions for the yutorina decode stage.
// Opcodes, instruction field positions, ALU and memory operation codes.
// Pure definitions; no logic, no latency, no backpressure.
package yutorina_instruction_decode_pkg;

    localparam int DEFAULT_DATA_WIDTH             = 32;
    localparam int DEFAULT_ADDRESS_WIDTH          = 30;
    localparam int DEFAULT_REGISTER_ADDRESS_WIDTH = 5;

    // Instruction field bit positions
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int DST_MSB    = 25;
    localparam int DST_LSB    = 21;
    localparam int SRC0_MSB   = 20;
    localparam int SRC0_LSB   = 16;
    localparam int SRC1_MSB   = 15;
    localparam int SRC1_LSB   = 11;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;

    localparam logic [31:0] INSTRUCTION_NOP = 32'h0000_0000;

    localparam logic [5:0] OPCODE_NOP  = 6'h00;
    localparam logic [5:0] OPCODE_ADD  = 6'h01;
    localparam logic [5:0] OPCODE_SUB  = 6'h02;
    localparam logic [5:0] OPCODE_AND  = 6'h03;
    localparam logic [5:0] OPCODE_OR   = 6'h04;
    localparam logic [5:0] OPCODE_XOR  = 6'h05;
    localparam logic [5:0] OPCODE_ADDI = 6'h06;
    localparam logic [5:0] OPCODE_ORI  = 6'h07;
    localparam logic [5:0] OPCODE_LDW  = 6'h08;
    localparam logic [5:0] OPCODE_STW  = 6'h09;
    localparam logic [5:0] OPCODE_BEQ  = 6'h0A;
    localparam logic [5:0] OPCODE_BNE  = 6'h0B;
    localparam logic [5:0] OPCODE_JR   = 6'h0C;

    typedef enum logic [3:0] {
        ALU_NONE = 4'd0,
        ALU_ADD  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_AND  = 4'd3,
        ALU_OR   = 4'd4,
        ALU_XOR  = 4'd5
    } alu_op_t;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } mem_op_t;

    // Selects what drives operand_b for the execute stage
    typedef enum logic [1:0] {
        OPB_ZERO = 2'd0,
        OPB_SRC1 = 2'd1,
        OPB_SEXT = 2'd2,
        OPB_ZEXT = 2'd3
    } operand_b_select_t;

endpackage

// File: rtl/yutorina_operand_forward.sv
// Resolves one register operand: EX result, then MEM result, then GPR file.
// Purely combinational, zero latency.
// No backpressure; r0 is never forwarded so it always reads the GPR value.
module yutorina_operand_forward
    import yutorina_instruction_decode_pkg::*;
#(
    parameter int DATA_WIDTH             = DEFAULT_DATA_WIDTH,
    parameter int REGISTER_ADDRESS_WIDTH = DEFAULT_REGISTER_ADDRESS_WIDTH
) (
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0]             gpr_data,
    input  logic                              ex_enable,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] ex_address,
    input  logic [DATA_WIDTH-1:0]             ex_data,
    input  logic                              mem_enable,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] mem_address,
    input  logic [DATA_WIDTH-1:0]             mem_data,
    output logic [DATA_WIDTH-1:0]             data
);

    // Youngest producer wins; the r0 guard keeps stale writes to r0 out
    always_comb begin
        data = gpr_data;
        if (address != '0) begin
            if (ex_enable && (ex_address == address)) begin
                data = ex_data;
            end else if (mem_enable && (mem_address == address)) begin
                data = mem_data;
            end
        end
    end

endmodule

// File: rtl/yutorina_instruction_decode.sv
// Decode stage: decodes fetch output, reads/forwards operands, resolves branches.
// 1 cycle: ID/EX register loads on the edge after the instruction arrives.
// stall_in holds ID/EX; load-use inserts a bubble and asks fetch to hold.
module yutorina_instruction_decode
    import yutorina_instruction_decode_pkg::*;
#(
    parameter int DATA_WIDTH             = DEFAULT_DATA_WIDTH,
    parameter int ADDRESS_WIDTH          = DEFAULT_ADDRESS_WIDTH,
    parameter int REGISTER_ADDRESS_WIDTH = DEFAULT_REGISTER_ADDRESS_WIDTH
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [ADDRESS_WIDTH-1:0]          if_program_counter,
    input  logic [DATA_WIDTH-1:0]             if_instruction,
    input  logic                              stall_in,
    input  logic                              flush,
    output logic [REGISTER_ADDRESS_WIDTH-1:0] gpr_read_address_0,
    output logic [REGISTER_ADDRESS_WIDTH-1:0] gpr_read_address_1,
    input  logic [DATA_WIDTH-1:0]             gpr_read_data_0,
    input  logic [DATA_WIDTH-1:0]             gpr_read_data_1,
    input  logic                              ex_forward_enable,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] ex_forward_address,
    input  logic [DATA_WIDTH-1:0]             ex_forward_data,
    input  logic                              mem_forward_enable,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] mem_forward_address,
    input  logic [DATA_WIDTH-1:0]             mem_forward_data,
    output logic                              load_use_stall,
    output logic                              branch_taken,
    output logic [ADDRESS_WIDTH-1:0]          branch_target,
    output logic [ADDRESS_WIDTH-1:0]          id_program_counter,
    output logic [3:0]                        id_alu_op,
    output logic [DATA_WIDTH-1:0]             id_operand_a,
    output logic [DATA_WIDTH-1:0]             id_operand_b,
    output logic [DATA_WIDTH-1:0]             id_store_data,
    output logic [REGISTER_ADDRESS_WIDTH-1:0] id_dest_address,
    output logic                              id_write_enable,
    output logic [1:0]                        id_mem_op,
    output logic                              id_illegal
);

    logic [5:0]                        opcode;
    logic [REGISTER_ADDRESS_WIDTH-1:0] dst, src0, src1;
    logic [15:0]                       imm16;
    logic [DATA_WIDTH-1:0]             imm_sext, imm_zext;

    assign opcode   = if_instruction[OPCODE_MSB:OPCODE_LSB];
    assign dst      = if_instruction[DST_MSB:DST_LSB];
    assign src0     = if_instruction[SRC0_MSB:SRC0_LSB];
    assign src1     = if_instruction[SRC1_MSB:SRC1_LSB];
    assign imm16    = if_instruction[IMM_MSB:IMM_LSB];
    assign imm_sext = {{(DATA_WIDTH-16){imm16[15]}}, imm16};
    assign imm_zext = {{(DATA_WIDTH-16){1'b0}}, imm16};

    alu_op_t           alu_op;
    mem_op_t           mem_op;
    operand_b_select_t operand_b_select;
    logic uses_src0, uses_src1, uses_dst, writes_dst, illegal;
    logic is_beq, is_bne, is_jr;

    // Opcode to control signals; undefined opcodes decode as NOP plus illegal
    always_comb begin
        alu_op           = ALU_NONE;
        mem_op           = MEM_NONE;
        operand_b_select = OPB_ZERO;
        uses_src0        = 1'b0;
        uses_src1        = 1'b0;
        uses_dst         = 1'b0;
        writes_dst       = 1'b0;
        illegal          = 1'b0;
        is_beq           = 1'b0;
        is_bne           = 1'b0;
        is_jr            = 1'b0;
        case (opcode)
            OPCODE_NOP: ;
            OPCODE_ADD, OPCODE_SUB, OPCODE_AND, OPCODE_OR, OPCODE_XOR: begin
                case (opcode)
                    OPCODE_ADD: alu_op = ALU_ADD;
                    OPCODE_SUB: alu_op = ALU_SUB;
                    OPCODE_AND: alu_op = ALU_AND;
                    OPCODE_OR:  alu_op = ALU_OR;
                    default:    alu_op = ALU_XOR;
                endcase
                uses_src0 = 1'b1; uses_src1 = 1'b1; writes_dst = 1'b1;
                operand_b_select = OPB_SRC1;
            end
            OPCODE_ADDI: begin
                alu_op = ALU_ADD; uses_src0 = 1'b1; writes_dst = 1'b1;
                operand_b_select = OPB_SEXT;
            end
            OPCODE_ORI: begin
                alu_op = ALU_OR; uses_src0 = 1'b1; writes_dst = 1'b1;
                operand_b_select = OPB_ZEXT;
            end
            OPCODE_LDW: begin
                alu_op = ALU_ADD; mem_op = MEM_LOAD; uses_src0 = 1'b1;
                writes_dst = 1'b1; operand_b_select = OPB_SEXT;
            end
            OPCODE_STW: begin
                alu_op = ALU_ADD; mem_op = MEM_STORE; uses_src0 = 1'b1;
                uses_src1 = 1'b1; operand_b_select = OPB_SEXT;
            end
            OPCODE_BEQ: begin is_beq = 1'b1; uses_src0 = 1'b1; uses_dst = 1'b1; end
            OPCODE_BNE: begin is_bne = 1'b1; uses_src0 = 1'b1; uses_dst = 1'b1; end
            OPCODE_JR:  begin is_jr  = 1'b1; uses_src0 = 1'b1; end
            default:    illegal = 1'b1;
        endcase
    end

    // Port 1 is shared: branches compare against the dst-field register
    assign gpr_read_address_0 = src0;
    assign gpr_read_address_1 = uses_dst ? dst : src1;

    logic [DATA_WIDTH-1:0] src0_value, src1_value, dst_value;

    yutorina_operand_forward #(.DATA_WIDTH(DATA_WIDTH), .REGISTER_ADDRESS_WIDTH(REGISTER_ADDRESS_WIDTH)) u_forward_src0 (
        .address(src0), .gpr_data(gpr_read_data_0),
        .ex_enable(ex_forward_enable), .ex_address(ex_forward_address), .ex_data(ex_forward_data),
        .mem_enable(mem_forward_enable), .mem_address(mem_forward_address), .mem_data(mem_forward_data),
        .data(src0_value));

    yutorina_operand_forward #(.DATA_WIDTH(DATA_WIDTH), .REGISTER_ADDRESS_WIDTH(REGISTER_ADDRESS_WIDTH)) u_forward_src1 (
        .address(src1), .gpr_data(gpr_read_data_1),
        .ex_enable(ex_forward_enable), .ex_address(ex_forward_address), .ex_data(ex_forward_data),
        .mem_enable(mem_forward_enable), .mem_address(mem_forward_address), .mem_data(mem_forward_data),
        .data(src1_value));

    yutorina_operand_forward #(.DATA_WIDTH(DATA_WIDTH), .REGISTER_ADDRESS_WIDTH(REGISTER_ADDRESS_WIDTH)) u_forward_dst (
        .address(dst), .gpr_data(gpr_read_data_1),
        .ex_enable(ex_forward_enable), .ex_address(ex_forward_address), .ex_data(ex_forward_data),
        .mem_enable(mem_forward_enable), .mem_address(mem_forward_address), .mem_data(mem_forward_data),
        .data(dst_value));

    // A load in ID/EX cannot forward its data yet; any consumer must wait a cycle
    always_comb begin
        load_use_stall = 1'b0;
        if ((id_mem_op == MEM_LOAD) && id_write_enable) begin
            load_use_stall = (uses_src0 && (src0 == id_dest_address))
                          || (uses_src1 && (src1 == id_dest_address))
                          || (uses_dst  && (dst  == id_dest_address));
        end
    end

    logic branch_condition;
    assign branch_condition = is_jr
                           || (is_beq && (src0_value == dst_value))
                           || (is_bne && (src0_value != dst_value));

    assign branch_taken  = branch_condition && !load_use_stall && !stall_in && !flush;
    assign branch_target = is_jr ? src0_value[ADDRESS_WIDTH-1:0]
                                 : if_program_counter + ADDRESS_WIDTH'(1) + imm_sext[ADDRESS_WIDTH-1:0];

    logic [DATA_WIDTH-1:0] operand_b;

    // Second operand selection from decoded control
    always_comb begin
        case (operand_b_select)
            OPB_SRC1: operand_b = src1_value;
            OPB_SEXT: operand_b = imm_sext;
            OPB_ZEXT: operand_b = imm_zext;
            default:  operand_b = '0;
        endcase
    end

    // ID/EX register: reset/flush bubble, stall holds, load-use bubble, else load
    always_ff @(posedge clock) begin
        if (reset || flush || (!stall_in && load_use_stall)) begin
            id_program_counter <= '0;
            id_alu_op          <= ALU_NONE;
            id_operand_a       <= '0;
            id_operand_b       <= '0;
            id_store_data      <= '0;
            id_dest_address    <= '0;
            id_write_enable    <= 1'b0;
            id_mem_op          <= MEM_NONE;
            id_illegal         <= 1'b0;
        end else if (!stall_in) begin
            id_program_counter <= if_program_counter;
            id_alu_op          <= alu_op;
            id_operand_a       <= uses_src0 && !uses_dst && !is_jr ? src0_value : '0;
            id_operand_b       <= operand_b;
            id_store_data      <= (mem_op == MEM_STORE) ? src1_value : '0;
            id_dest_address    <= writes_dst ? dst : '0;
            id_write_enable    <= writes_dst && (dst != '0);
            id_mem_op          <= mem_op;
            id_illegal         <= illegal;
        end
    end

endmodule
